// File: rtl/dir_tag_store_mw.sv
//------------------------------------------------------------------------------
// dir_tag_store_mw
//
// Set-associative directory tag store. Each of the IDX_CNT sets holds WAYS
// entries of {valid, tag}. A lookup reads one set, compares every way against
// the request tag and returns the way contents, a lowest-way-wins one-hot hit
// vector and a one-hot allocation victim. The results are registered, so they
// appear one cycle after the request. An update presented in the same cycle to
// the same set is merged into the lookup result way by way.
//
// The valid array is never reset directly. After reset a sweep walks every set
// and clears its valid bits, one set per cycle. Lookups and updates are ignored
// until that sweep has finished and ready is high.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   ready        high once every set has been invalidated
//   rd_req       lookup request
//   rd_idx       lookup set index
//   rd_tag       tag compared against every way
//   rd_vld       one-cycle pulse marking a lookup result
//   rd_tags_out  tags of all ways, way w at [w*TAG_SIZE +: TAG_SIZE]
//   rd_valid_out valid bit per way
//   rd_hit       some valid way matched rd_tag
//   rd_hit_way   one-hot matching way, lowest index wins
//   rd_victim    one-hot way to allocate into
//   wr_en        update request
//   wr_idx       update set index
//   wr_way       ways to update, any subset
//   wr_tag       tag written into every selected way
//   wr_inval     1 clears the selected valid bits, 0 writes tag and sets valid
//------------------------------------------------------------------------------
module dir_tag_store_mw #(
   parameter int TAG_SIZE = 18,
   parameter int IDX_CNT  = 512,
   parameter int WAYS     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       ready,
   input  logic                       rd_req,
   input  logic [$clog2(IDX_CNT)-1:0] rd_idx,
   input  logic [TAG_SIZE-1:0]        rd_tag,
   output logic                       rd_vld,
   output logic [TAG_SIZE*WAYS-1:0]   rd_tags_out,
   output logic [WAYS-1:0]            rd_valid_out,
   output logic                       rd_hit,
   output logic [WAYS-1:0]            rd_hit_way,
   output logic [WAYS-1:0]            rd_victim,
   input  logic                       wr_en,
   input  logic [$clog2(IDX_CNT)-1:0] wr_idx,
   input  logic [WAYS-1:0]            wr_way,
   input  logic [TAG_SIZE-1:0]        wr_tag,
   input  logic                       wr_inval
);

   localparam int IDX_W = $clog2(IDX_CNT);
   localparam int WAY_W = $clog2(WAYS);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         sweepCnt_q, sweepCnt_d;
   logic [WAY_W-1:0]         rr_q, rr_d;

   logic                     rdVld_q, rdVld_d;
   logic [TAG_SIZE*WAYS-1:0] rdTags_q, rdTags_d;
   logic [WAYS-1:0]          rdValid_q, rdValid_d;
   logic                     rdHit_q, rdHit_d;
   logic [WAYS-1:0]          rdHitWay_q, rdHitWay_d;
   logic [WAYS-1:0]          rdVictim_q, rdVictim_d;

   // Storage arrays, no reset: the sweep makes their initial content irrelevant
   logic [TAG_SIZE*WAYS-1:0] tagMem_q   [IDX_CNT];
   logic [WAYS-1:0]          validMem_q [IDX_CNT];

   logic                     wrAccepted;
   logic                     tagWrEn;
   logic                     validWrEn;
   logic [IDX_W-1:0]         validWrIdx;
   logic [WAYS-1:0]          validWrData;

   logic [TAG_SIZE*WAYS-1:0] mergedTags;
   logic [WAYS-1:0]          mergedValid;
   logic [WAYS-1:0]          hitVec;
   logic [WAYS-1:0]          hitOneHot;
   logic [WAYS-1:0]          invalidVec;
   logic [WAYS-1:0]          lowInvalid;
   logic [WAYS-1:0]          rrOneHot;
   logic                     allValid;

   assign ready      = (state_q == ST_RUN);
   assign wrAccepted = (state_q == ST_RUN) && wr_en;
   assign tagWrEn    = wrAccepted && !wr_inval;

   // Valid-array write port. During the sweep it clears one whole set per
   // cycle; afterwards it applies updates as a read-modify-write of the set's
   // valid vector so that unselected ways keep their bits.
   always_comb begin
      validWrEn   = 1'b0;
      validWrIdx  = wr_idx;
      validWrData = validMem_q[wr_idx];
      if (state_q == ST_INIT) begin
         validWrEn   = 1'b1;
         validWrIdx  = sweepCnt_q;
         validWrData = '0;
      end else if (wrAccepted && (wr_way != '0)) begin
         validWrEn = 1'b1;
         if (wr_inval) begin
            validWrData = validMem_q[wr_idx] & ~wr_way;
         end else begin
            validWrData = validMem_q[wr_idx] | wr_way;
         end
      end
   end

   // Storage update. Tags are only written on a non-invalidating update, so an
   // invalidate leaves the old tag in place.
   always_ff @(posedge clk) begin
      if (validWrEn) begin
         validMem_q[validWrIdx] <= validWrData;
      end
      if (tagWrEn) begin
         for (int w = 0; w < WAYS; w++) begin
            if (wr_way[w]) begin
               tagMem_q[wr_idx][w*TAG_SIZE +: TAG_SIZE] <= wr_tag;
            end
         end
      end
   end

   // Read the addressed set and overlay any same-cycle update to that set so
   // the lookup reports what the set will hold after this edge.
   always_comb begin
      mergedTags  = tagMem_q[rd_idx];
      mergedValid = validMem_q[rd_idx];
      if (wrAccepted && (wr_idx == rd_idx)) begin
         for (int w = 0; w < WAYS; w++) begin
            if (wr_way[w]) begin
               if (wr_inval) begin
                  mergedValid[w] = 1'b0;
               end else begin
                  mergedValid[w]                         = 1'b1;
                  mergedTags[w*TAG_SIZE +: TAG_SIZE] = wr_tag;
               end
            end
         end
      end
   end

   // Tag compare and victim choice on the merged set. x & (~x + 1) isolates
   // the lowest set bit, which gives both the lowest matching way and the
   // lowest invalid way without a priority chain.
   always_comb begin
      hitVec = '0;
      for (int w = 0; w < WAYS; w++) begin
         hitVec[w] = mergedValid[w] && (mergedTags[w*TAG_SIZE +: TAG_SIZE] == rd_tag);
      end
      hitOneHot  = hitVec & (~hitVec + WAYS'(1));
      invalidVec = ~mergedValid;
      lowInvalid = invalidVec & (~invalidVec + WAYS'(1));
      allValid   = &mergedValid;
      rrOneHot   = WAYS'(1) << rr_q;
   end

   // Sweep/run sequencing and lookup result capture. Result registers hold
   // their last value between lookups; only rd_vld returns to zero. The
   // round-robin pointer advances only when a full set misses, because that is
   // the only case where it actually picked the victim.
   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      rr_d       = rr_q;
      rdVld_d    = 1'b0;
      rdTags_d   = rdTags_q;
      rdValid_d  = rdValid_q;
      rdHit_d    = rdHit_q;
      rdHitWay_d = rdHitWay_q;
      rdVictim_d = rdVictim_q;
      case (state_q)
         ST_INIT: begin
            sweepCnt_d = sweepCnt_q + 1'b1;
            if (sweepCnt_q == IDX_W'(IDX_CNT - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_req) begin
               rdVld_d    = 1'b1;
               rdTags_d   = mergedTags;
               rdValid_d  = mergedValid;
               rdHit_d    = |hitVec;
               rdHitWay_d = hitOneHot;
               rdVictim_d = allValid ? rrOneHot : lowInvalid;
               if (!(|hitVec) && allValid) begin
                  rr_d = rr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and result registers. Reset restarts the sweep from set 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         sweepCnt_q <= '0;
         rr_q       <= '0;
         rdVld_q    <= 1'b0;
         rdTags_q   <= '0;
         rdValid_q  <= '0;
         rdHit_q    <= 1'b0;
         rdHitWay_q <= '0;
         rdVictim_q <= '0;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         rr_q       <= rr_d;
         rdVld_q    <= rdVld_d;
         rdTags_q   <= rdTags_d;
         rdValid_q  <= rdValid_d;
         rdHit_q    <= rdHit_d;
         rdHitWay_q <= rdHitWay_d;
         rdVictim_q <= rdVictim_d;
      end
   end

   assign rd_vld       = rdVld_q;
   assign rd_tags_out  = rdTags_q;
   assign rd_valid_out = rdValid_q;
   assign rd_hit       = rdHit_q;
   assign rd_hit_way   = rdHitWay_q;
   assign rd_victim    = rdVictim_q;

endmodule

// File: tb/tb_dir_tag_store_mw.sv
//------------------------------------------------------------------------------
// tb_dir_tag_store_mw
//
// Bench for dir_tag_store_mw. A behavioural model holds the directory as plain
// per-set, per-way arrays and derives every lookup result from the set
// contents. A compare process checks all outputs against that model on every
// falling edge. Directed scenarios with literal expectations are followed by a
// randomized phase and a mid-run reset.
//------------------------------------------------------------------------------
module tb_dir_tag_store_mw;

   localparam int TAG_SIZE = 18;
   localparam int IDX_CNT  = 512;
   localparam int WAYS     = 8;
   localparam int IDX_W    = $clog2(IDX_CNT);

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     ready;
   logic                     rdReq;
   logic [IDX_W-1:0]         rdIdx;
   logic [TAG_SIZE-1:0]      rdTag;
   logic                     rdVld;
   logic [TAG_SIZE*WAYS-1:0] rdTagsOut;
   logic [WAYS-1:0]          rdValidOut;
   logic                     rdHit;
   logic [WAYS-1:0]          rdHitWay;
   logic [WAYS-1:0]          rdVictim;
   logic                     wrEn;
   logic [IDX_W-1:0]         wrIdx;
   logic [WAYS-1:0]          wrWay;
   logic [TAG_SIZE-1:0]      wrTag;
   logic                     wrInval;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: directory contents and the expected output registers
   logic [TAG_SIZE-1:0] mTag   [IDX_CNT][WAYS];
   bit                  mValid [IDX_CNT][WAYS];
   bit                  mKnown [IDX_CNT][WAYS];
   int                  mRr     = 0;
   int                  mEdges  = 0;
   bit                  modelLive = 1'b0;
   bit                  eVld    = 1'b0;
   bit                  eHit    = 1'b0;
   logic [WAYS-1:0]     eHitWay = '0;
   logic [WAYS-1:0]     eVictim = '0;
   logic [WAYS-1:0]     eValid  = '0;
   logic [TAG_SIZE-1:0] eTag   [WAYS];
   bit                  eKnown [WAYS];

   always #5 clk = ~clk;

   dir_tag_store_mw #(
      .TAG_SIZE (TAG_SIZE),
      .IDX_CNT  (IDX_CNT),
      .WAYS     (WAYS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ready        (ready),
      .rd_req       (rdReq),
      .rd_idx       (rdIdx),
      .rd_tag       (rdTag),
      .rd_vld       (rdVld),
      .rd_tags_out  (rdTagsOut),
      .rd_valid_out (rdValidOut),
      .rd_hit       (rdHit),
      .rd_hit_way   (rdHitWay),
      .rd_victim    (rdVictim),
      .wr_en        (wrEn),
      .wr_idx       (wrIdx),
      .wr_way       (wrWay),
      .wr_tag       (wrTag),
      .wr_inval     (wrInval)
   );

   // One comparison: counts it and reports a mismatch with both values
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge; they are consumed by
   // the next rising edge.
   task automatic applyStimulus(input bit req, input int ridx, input int rtag,
                                input bit we, input int widx, input int wway,
                                input int wtag, input bit winv);
      @(posedge clk);
      #1;
      rdReq   = req;
      rdIdx   = ridx[IDX_W-1:0];
      rdTag   = rtag[TAG_SIZE-1:0];
      wrEn    = we;
      wrIdx   = widx[IDX_W-1:0];
      wrWay   = wway[WAYS-1:0];
      wrTag   = wtag[TAG_SIZE-1:0];
      wrInval = winv;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   // Lookup result from the set contents plus any same-cycle update
   task automatic modelLookup();
      logic [TAG_SIZE-1:0] t [WAYS];
      bit v [WAYS];
      bit k [WAYS];
      int firstHit;
      int firstFree;
      for (int w = 0; w < WAYS; w++) begin
         t[w] = mTag[rdIdx][w];
         v[w] = mValid[rdIdx][w];
         k[w] = mKnown[rdIdx][w];
      end
      if (wrEn && (wrIdx == rdIdx)) begin
         for (int w = 0; w < WAYS; w++) begin
            if (wrWay[w]) begin
               if (wrInval) begin
                  v[w] = 1'b0;
               end else begin
                  t[w] = wrTag;
                  v[w] = 1'b1;
                  k[w] = 1'b1;
               end
            end
         end
      end
      firstHit  = -1;
      firstFree = -1;
      for (int w = 0; w < WAYS; w++) begin
         if (firstHit < 0 && v[w] && t[w] == rdTag) firstHit = w;
         if (firstFree < 0 && !v[w]) firstFree = w;
      end
      eVld    = 1'b1;
      eHit    = (firstHit >= 0);
      eHitWay = '0;
      if (eHit) eHitWay[firstHit] = 1'b1;
      eVictim = '0;
      if (firstFree >= 0) eVictim[firstFree] = 1'b1;
      else eVictim[mRr] = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
         eValid[w] = v[w];
         eTag[w]   = t[w];
         eKnown[w] = k[w];
      end
      if (!eHit && firstFree < 0) mRr = (mRr + 1) % WAYS;
   endtask

   task automatic modelWrite();
      for (int w = 0; w < WAYS; w++) begin
         if (wrWay[w]) begin
            if (wrInval) begin
               mValid[wrIdx][w] = 1'b0;
            end else begin
               mTag[wrIdx][w]   = wrTag;
               mValid[wrIdx][w] = 1'b1;
               mKnown[wrIdx][w] = 1'b1;
            end
         end
      end
   endtask

   // Model: after reset every set reads as invalid once IDX_CNT edges have
   // passed; before that all requests are ignored. Tags survive reset since
   // the storage is not cleared.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         modelLive = 1'b1;
         mEdges    = 0;
         mRr       = 0;
         eVld      = 1'b0;
         eHit      = 1'b0;
         eHitWay   = '0;
         eVictim   = '0;
         eValid    = '0;
         for (int w = 0; w < WAYS; w++) begin
            eTag[w]   = '0;
            eKnown[w] = 1'b1;
         end
         for (int i = 0; i < IDX_CNT; i++) begin
            for (int w = 0; w < WAYS; w++) mValid[i][w] = 1'b0;
         end
      end else begin
         if (mEdges >= IDX_CNT) begin
            if (rdReq) modelLookup();
            else eVld = 1'b0;
            if (wrEn) modelWrite();
         end else begin
            eVld = 1'b0;
         end
         if (mEdges < IDX_CNT) mEdges++;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("ready", ready, mEdges >= IDX_CNT);
         checkOutput("rd_vld", rdVld, eVld);
         checkOutput("rd_hit", rdHit, eHit);
         checkOutput("rd_hit_way", rdHitWay, eHitWay);
         checkOutput("rd_victim", rdVictim, eVictim);
         checkOutput("rd_valid_out", rdValidOut, eValid);
         for (int w = 0; w < WAYS; w++) begin
            if (eKnown[w]) checkOutput("rd_tags_out", rdTagsOut[w*TAG_SIZE +: TAG_SIZE], eTag[w]);
         end
      end
   end

   // Release reset and step through the sweep, pinning where ready rises
   task automatic runSweep(input int reqAt);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= IDX_CNT; k++) begin
         applyStimulus(k == reqAt, $urandom_range(0, IDX_CNT - 1), 0, 1'b0, 0, 0, 0, 1'b0);
         if (k == reqAt + 1) checkOutput("init_no_vld", rdVld, 0);
         if (k == IDX_CNT - 1) checkOutput("sweep_ready_low", ready, 0);
         if (k == IDX_CNT) checkOutput("sweep_ready_high", ready, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WAYS-1:0] expVic [4];
      bit rq;
      bit we;
      bit inv;
      expVic = '{8'h01, 8'h02, 8'h04, 8'h08};

      rdReq = 0; rdIdx = '0; rdTag = '0;
      wrEn = 0; wrIdx = '0; wrWay = '0; wrTag = '0; wrInval = 0;

      // Reset values
      @(posedge clk);
      #1;
      checkOutput("reset_ready", ready, 0);
      checkOutput("reset_rd_vld", rdVld, 0);
      checkOutput("reset_hit_way", rdHitWay, 0);
      checkOutput("reset_victim", rdVictim, 0);
      checkOutput("reset_valid_out", rdValidOut, 0);
      checkOutput("reset_tags_w0", rdTagsOut[TAG_SIZE-1:0], 0);
      repeat (2) @(posedge clk);
      runSweep(100);

      // Write then look up the same tag in a later cycle
      applyStimulus(1'b0, 0, 0, 1'b1, 5, 'h04, 'h1ABCD, 1'b0);
      applyStimulus(1'b1, 5, 'h1ABCD, 1'b0, 0, 0, 0, 1'b0);
      idle();
      checkOutput("wr_rd_vld", rdVld, 1);
      checkOutput("wr_rd_hit", rdHit, 1);
      checkOutput("wr_rd_hit_way", rdHitWay, 'h04);
      checkOutput("wr_rd_valid_out", rdValidOut, 'h04);
      checkOutput("wr_rd_victim", rdVictim, 'h01);
      checkOutput("wr_rd_tag_w2", rdTagsOut[2*TAG_SIZE +: TAG_SIZE], 'h1ABCD);

      // Same-cycle forwarding of a write, then of an invalidate
      applyStimulus(1'b1, 7, 'h00123, 1'b1, 7, 'h01, 'h00123, 1'b0);
      idle();
      checkOutput("fwd_hit", rdHit, 1);
      checkOutput("fwd_hit_way", rdHitWay, 'h01);
      applyStimulus(1'b1, 7, 'h00123, 1'b1, 7, 'h01, 'h00123, 1'b1);
      idle();
      checkOutput("fwd_inval_hit", rdHit, 0);
      checkOutput("fwd_inval_valid0", rdValidOut[0], 0);

      // Full set, repeated misses walk the round-robin victim
      for (int w = 0; w < WAYS; w++) begin
         applyStimulus(1'b0, 0, 0, 1'b1, 9, 1 << w, w, 1'b0);
      end
      applyStimulus(1'b1, 9, 'h3FFFF, 1'b0, 0, 0, 0, 1'b0);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(j < 3, 9, 'h3FFFF, 1'b0, 0, 0, 0, 1'b0);
         checkOutput("rr_victim", rdVictim, expVic[j]);
         checkOutput("rr_hit", rdHit, 0);
      end

      // Two matching ways: lowest wins
      applyStimulus(1'b0, 0, 0, 1'b1, 3, 'h0A, 'h00042, 1'b0);
      applyStimulus(1'b1, 3, 'h00042, 1'b0, 0, 0, 0, 1'b0);
      idle();
      checkOutput("multi_hit", rdHit, 1);
      checkOutput("multi_hit_way", rdHitWay, 'h02);

      // Randomized traffic on a few sets with a small tag space
      for (int n = 0; n < 3000; n++) begin
         rq  = ($urandom_range(0, 3) != 0);
         we  = ($urandom_range(0, 2) != 0);
         inv = ($urandom_range(0, 5) == 0);
         applyStimulus(rq, $urandom_range(0, 7), $urandom_range(0, 5),
                       we, $urandom_range(0, 7), $urandom_range(0, 255),
                       $urandom_range(0, 5), inv);
      end

      // Reset mid-run with a result on the outputs
      applyStimulus(1'b1, 5, 'h1ABCD, 1'b0, 0, 0, 0, 1'b0);
      idle();
      checkOutput("inflight_vld", rdVld, 1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midreset_rd_vld", rdVld, 0);
      checkOutput("midreset_ready", ready, 0);
      repeat (3) @(posedge clk);
      runSweep(50);
      applyStimulus(1'b1, 5, 'h1ABCD, 1'b0, 0, 0, 0, 1'b0);
      idle();
      checkOutput("post_reset_vld", rdVld, 1);
      checkOutput("post_reset_hit", rdHit, 0);
      checkOutput("post_reset_valid_out", rdValidOut, 0);

      repeat (2) idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
